// File: rtl/seq_mag_comp_pkg.sv
// ----------------------------------------------------------------------------
// seq_comp_pkg
//   Shared types for the sequential magnitude comparator:
//     state_t   - controller states (IDLE, CMP, DONE)
//     cmp_res_t - comparison outcome (RES_EQ, RES_LT, RES_GT)
//     res_flags - converts a cmp_res_t into one-hot {eq, lt, gt} flags
// ----------------------------------------------------------------------------
package seq_comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_LT = 2'd1,
      RES_GT = 2'd2
   } cmp_res_t;

   // Returns {eq, lt, gt}; exactly one bit set for every legal result.
   function automatic logic [2:0] res_flags(input cmp_res_t r);
      logic [2:0] f;
      f = 3'b000;
      case (r)
         RES_EQ:  f = 3'b100;
         RES_LT:  f = 3'b010;
         RES_GT:  f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

   // Cascade priority: GT wins, then LT, else EQ. Illegal codes
   // (several bits set, or none) therefore resolve deterministically.
   function automatic cmp_res_t cas_resolve(input logic gt, input logic lt);
      cmp_res_t r;
      if (gt)      r = RES_GT;
      else if (lt) r = RES_LT;
      else         r = RES_EQ;
      return r;
   endfunction

endpackage

// File: rtl/seq_mag_comp_if.sv
// ----------------------------------------------------------------------------
// seq_mag_comp_if
//   Operand/result bus of the sequential magnitude comparator.
//   Optional macro: SEQ_COMP_SIGNED_EN adds signed_mode.
//
//   Handshake: a transfer happens on a rising clock edge where both valid and
//   ready are high. Input side: in_valid/in_ready qualify a, b, cas_* (and
//   signed_mode). Output side: out_valid/out_ready qualify the flags. The
//   producer must hold its payload stable while valid is high and ready low.
//
//   Signals:
//     in_valid, in_ready      - operand handshake
//     a, b                    - WIDTH-bit operands
//     cas_eq, cas_lt, cas_gt  - cascade from a less-significant stage
//     out_valid, out_ready    - result handshake
//     a_eq_b, a_ls_b, a_gt_b  - one-hot result while out_valid
//     busy                    - comparison in progress
//     signed_mode             - (SEQ_COMP_SIGNED_EN) two's-complement order
//   Modports: master = operand source / result sink, slave = comparator.
// ----------------------------------------------------------------------------
interface seq_mag_comp_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cas_eq;
   logic             cas_lt;
   logic             cas_gt;
   logic             out_valid;
   logic             out_ready;
   logic             a_eq_b;
   logic             a_ls_b;
   logic             a_gt_b;
   logic             busy;
`ifdef SEQ_COMP_SIGNED_EN
   logic             signed_mode;

   modport master (
      output in_valid, a, b, cas_eq, cas_lt, cas_gt, out_ready, signed_mode,
      input  in_ready, out_valid, a_eq_b, a_ls_b, a_gt_b, busy
   );

   modport slave (
      input  in_valid, a, b, cas_eq, cas_lt, cas_gt, out_ready, signed_mode,
      output in_ready, out_valid, a_eq_b, a_ls_b, a_gt_b, busy
   );
`else
   modport master (
      output in_valid, a, b, cas_eq, cas_lt, cas_gt, out_ready,
      input  in_ready, out_valid, a_eq_b, a_ls_b, a_gt_b, busy
   );

   modport slave (
      input  in_valid, a, b, cas_eq, cas_lt, cas_gt, out_ready,
      output in_ready, out_valid, a_eq_b, a_ls_b, a_gt_b, busy
   );
`endif

endinterface

// File: rtl/seq_mag_comp_slice_cmp.sv
// ----------------------------------------------------------------------------
// slice_cmp
//   Combinational SLICE-bit unsigned comparator. When inv_msb is set, bit
//   SLICE-1 of both operands is inverted before comparing, which turns the
//   unsigned order of the most-significant slice into two's-complement order.
//
//   Ports:
//     a, b    - slice operands
//     inv_msb - invert the top bit of both operands
//     eq      - a == b
//     lt      - a <  b (after optional inversion)
//     gt      - a >  b (after optional inversion)
// ----------------------------------------------------------------------------
module slice_cmp #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             inv_msb,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   logic [SLICE-1:0] flip;
   logic [SLICE-1:0] a_m;
   logic [SLICE-1:0] b_m;

   always_comb begin
      flip            = '0;
      flip[SLICE-1]   = inv_msb;
   end

   assign a_m = a ^ flip;
   assign b_m = b ^ flip;

   assign eq = (a_m == b_m);
   assign lt = (a_m <  b_m);
   assign gt = (a_m >  b_m);

endmodule

// File: rtl/seq_mag_comp.sv
// ----------------------------------------------------------------------------
// seq_mag_comp
//   Cascadable magnitude comparator that walks the operands one SLICE-bit
//   digit per clock from the MSB down, stopping at the first unequal digit.
//   If every digit is equal the registered cascade inputs decide.
//   Optional macro: SEQ_COMP_SIGNED_EN (signed_mode on the bus; MSB slice
//   compared in two's-complement order when set).
//
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset
//     bus       - seq_mag_comp_if slave (handshakes, operands, result)
//     fsm_state - current controller state (debug visibility)
//
//   Timing: the accept edge moves IDLE->CMP; the result edge k (1..NSLICE)
//   later moves CMP->DONE with out_valid high; out_ready returns to IDLE.
// ----------------------------------------------------------------------------
module seq_mag_comp
   import seq_comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic            clk,
   input  logic            rst,
   seq_mag_comp_if.slave   bus,
   output state_t          fsm_state
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NSLICE - 1);

   state_t                        state;
   logic [IDX_W-1:0]              idx;
   logic [NSLICE-1:0][SLICE-1:0]  a_q;
   logic [NSLICE-1:0][SLICE-1:0]  b_q;
   cmp_res_t                      cas_q;
   logic                          signed_q;
   logic                          out_valid_q;
   logic [2:0]                    flags_q;

   logic [SLICE-1:0]              a_sl;
   logic [SLICE-1:0]              b_sl;
   logic                          sl_eq;
   logic                          sl_lt;
   logic                          sl_gt;
   logic                          inv_msb;
   logic                          signed_in;

`ifdef SEQ_COMP_SIGNED_EN
   assign signed_in = bus.signed_mode;
`else
   assign signed_in = 1'b0;
`endif

   // Slice mux: one comparator, digit selected by idx.
   assign a_sl    = a_q[idx];
   assign b_sl    = b_q[idx];
   // Sign inversion applies only to the most-significant digit.
   assign inv_msb = signed_q && (idx == IDX_MAX);

   slice_cmp #(
      .SLICE (SLICE)
   ) u_slice_cmp (
      .a       (a_sl),
      .b       (b_sl),
      .inv_msb (inv_msb),
      .eq      (sl_eq),
      .lt      (sl_lt),
      .gt      (sl_gt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= IDX_MAX;
         a_q         <= '0;
         b_q         <= '0;
         cas_q       <= RES_EQ;
         signed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         flags_q     <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is high in IDLE, so in_valid alone completes the accept.
               if (bus.in_valid) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  cas_q    <= cas_resolve(bus.cas_gt, bus.cas_lt);
                  signed_q <= signed_in;
                  idx      <= IDX_MAX;
                  state    <= CMP;
               end
            end
            CMP: begin
               if (!sl_eq) begin
                  flags_q     <= res_flags(sl_lt ? RES_LT : RES_GT);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else if (idx == '0) begin
                  flags_q     <= res_flags(cas_q);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  flags_q     <= 3'b000;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               flags_q     <= 3'b000;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.busy      = (state == CMP);
   assign bus.out_valid = out_valid_q;
   assign bus.a_eq_b    = flags_q[2];
   assign bus.a_ls_b    = flags_q[1];
   assign bus.a_gt_b    = flags_q[0];
   assign fsm_state     = state;

   // sl_gt is implied by !sl_eq && !sl_lt; kept on the comparator for clarity.
   logic unused_ok;
   assign unused_ok = sl_gt ^ bus.cas_eq;

endmodule

// File: tb/tb_seq_mag_comp.sv
// ----------------------------------------------------------------------------
// tb_seq_mag_comp
//   Directed bench for seq_mag_comp (WIDTH=32, SLICE=4). Vector table covers
//   single-slice decisions, full-length cascades, illegal cascade codes and
//   mid-word decisions; hand-written sequences cover DONE back-pressure and
//   reset during CMP. Signed vectors run when SEQ_COMP_SIGNED_EN is defined.
// ----------------------------------------------------------------------------
module tb_seq_mag_comp;
   import seq_comp_pkg::*;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 4;
   localparam int NSLICE = WIDTH / SLICE;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       cas;    // {cas_eq, cas_lt, cas_gt}
      logic             sgn;
      int               lat;    // expected edges from accept to out_valid
      logic [2:0]       flags;  // expected {a_eq_b, a_ls_b, a_gt_b}
   } vec_t;

   logic   clk;
   logic   rst;
   state_t fsm_state;
   int     total;
   int     bad;

   seq_mag_comp_if #(.WIDTH(WIDTH)) bus ();

   seq_mag_comp #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] flags_now();
      return {bus.a_eq_b, bus.a_ls_b, bus.a_gt_b};
   endfunction

   // ---------------- drivers ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_and_wait(input vec_t v, input string tag,
                                 output int lat, output int busy_n);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.a        = v.a;
      bus.b        = v.b;
      {bus.cas_eq, bus.cas_lt, bus.cas_gt} = v.cas;
`ifdef SEQ_COMP_SIGNED_EN
      bus.signed_mode = v.sgn;
`endif
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs after the accept edge; they must have no effect.
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      {bus.cas_eq, bus.cas_lt, bus.cas_gt} = 3'($urandom_range(0, 7));
`ifdef SEQ_COMP_SIGNED_EN
      bus.signed_mode = ~v.sgn;
`endif
      lat    = 0;
      busy_n = 0;
      while (!bus.out_valid && lat < NSLICE + 4) begin
         if (bus.busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_valid_cleared"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_flags_cleared"}, 32'(flags_now()), 32'd0);
      check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      int busy_n;
      start_and_wait(v, tag, lat, busy_n);
      check({tag, "_latency"}, 32'(lat), 32'(v.lat));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.lat));
      check({tag, "_flags"}, 32'(flags_now()), 32'(v.flags));
      check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      release_result(tag);
   endtask

   // ---------------- stimulus ----------------
   vec_t vecs [9];
   vec_t sv   [2];

   initial begin
      int   lat;
      int   busy_n;
      int   stray;
      vec_t v;

      total = 0;
      bad   = 0;

      vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b0, 1, 3'b001};
      vecs[1] = '{32'h1234_5678, 32'h1234_5678, 3'b010, 1'b0, 8, 3'b010};
      vecs[2] = '{32'h1234_5678, 32'h1234_5678, 3'b100, 1'b0, 8, 3'b100};
      vecs[3] = '{32'h1234_5678, 32'h1234_5678, 3'b011, 1'b0, 8, 3'b001};
      vecs[4] = '{32'h1234_5670, 32'h1234_5671, 3'b100, 1'b0, 8, 3'b010};
      vecs[5] = '{32'h0000_0010, 32'h0000_0001, 3'b010, 1'b0, 7, 3'b001};
      vecs[6] = '{32'hABCD_0000, 32'hABCE_0000, 3'b001, 1'b0, 4, 3'b010};
      vecs[7] = '{32'h0000_0000, 32'h0000_0000, 3'b000, 1'b0, 8, 3'b100};
      vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, 1, 3'b001};

      sv[0]   = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1, 3'b010};
      sv[1]   = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 1'b1, 1, 3'b001};

      // clock/reset
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cas_eq    = 1'b0;
      bus.cas_lt    = 1'b0;
      bus.cas_gt    = 1'b0;
      bus.out_ready = 1'b0;
`ifdef SEQ_COMP_SIGNED_EN
      bus.signed_mode = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_flags", 32'(flags_now()), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // table-driven vectors
      for (int i = 0; i < 9; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef SEQ_COMP_SIGNED_EN
      for (int i = 0; i < 2; i++)
         run_vec(sv[i], $sformatf("signed%0d", i));
`endif

      // back-pressure in DONE with new operands offered
      v = '{32'h0000_0005, 32'h0000_0003, 3'b000, 1'b0, 8, 3'b001};
      start_and_wait(v, "hold", lat, busy_n);
      check("hold_latency", 32'(lat), 32'd8);
      bus.a        = 32'h0000_0000;
      bus.b        = 32'h0000_0001;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold_c%0d_valid", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("hold_c%0d_flags", c), 32'(flags_now()), 32'b001);
         check($sformatf("hold_c%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      release_result("hold");
      check("hold_state_idle", 32'(fsm_state), 32'(IDLE));
      run_vec('{32'h0000_0000, 32'h0000_0001, 3'b000, 1'b0, 8, 3'b010}, "after_hold");

      // reset during the third CMP cycle
      bus.a        = 32'd1;
      bus.b        = 32'd2;
      {bus.cas_eq, bus.cas_lt, bus.cas_gt} = 3'b100;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_in_ready_low", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_state", 32'(fsm_state), 32'(IDLE));
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_flags", 32'(flags_now()), 32'd0);
      check("midrst_busy_low", 32'(bus.busy), 32'd0);
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid || bus.busy) stray++;
      end
      check("midrst_no_stale", 32'(stray), 32'd0);
      run_vec('{32'h0000_0001, 32'h0000_0002, 3'b000, 1'b0, 8, 3'b010}, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
